// File: rtl/tff_counter_pkg.sv
// ============================================================================
// Module : tff_pkg
// Brief  : Mode encoding shared by the tff_counter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tff_pkg;

  localparam int c_mode_w = 2;

  typedef enum logic [c_mode_w-1:0] {
    TOGGLE = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    LOAD   = 2'd3
  } mode_t;

endpackage

`default_nettype wire

// File: rtl/tff_counter_if.sv
// ============================================================================
// Module : tff_counter_if
// Brief  : Control/status bundle of tff_counter; master drives, slave counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tff_counter_if
  import tff_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;
  logic             carry;

  modport master (output en, mode, t, d, input q, qn, tc, carry);
  modport slave  (input en, mode, t, d, output q, qn, tc, carry);

endinterface

`default_nettype wire

// File: rtl/tff_counter_cell.sv
// ============================================================================
// Module : tff_cell
// Brief  : Single T flip-flop with async active-high clear and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_cell (
  input  wire logic clk,
  input  wire logic clr,
  input  wire logic en,
  input  wire logic tog,
  output      logic q,
  output      logic qn
);

  logic r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= 1'b0;
    end else if (en && tog) begin
      r_q <= ~r_q;
    end
  end

  assign q  = r_q;
  assign qn = ~r_q;

endmodule

`default_nettype wire

// File: rtl/tff_counter.sv
// ============================================================================
// Module : tff_counter
// Brief  : WIDTH-bit T-flop bank: toggle / up / down / load, tc and carry.
//          Optional modulo wrap and load clamp under TFF_COUNTER_MODULO_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2**WIDTH
) (
  input wire logic     clk,
  input wire logic     clr,
  tff_counter_if.slave bus
);

`ifdef TFF_COUNTER_MODULO_EN
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
`endif

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_tog;
  logic             w_tc;
  logic             r_carry;

`ifdef TFF_COUNTER_MODULO_EN
  // Modulo build: form the next state, then derive the per-cell toggle terms.
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = w_q;
    case (bus.mode)
      TOGGLE:  w_next = w_q ^ bus.t;
      UP:      w_next = (w_q == c_max) ? '0 : w_q + WIDTH'(1);
      DOWN:    w_next = (w_q == '0) ? c_max : w_q - WIDTH'(1);
      LOAD:    w_next = (bus.d > c_max) ? c_max : bus.d;
      default: w_next = w_q;
    endcase
    w_tog = w_q ^ w_next;
  end
`else
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;

  assign w_up[0] = 1'b1;
  assign w_dn[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_terms
    assign w_up[i] = &w_q[i-1:0];
    assign w_dn[i] = &w_qn[i-1:0];
  end

  always_comb begin
    w_tog = '0;
    case (bus.mode)
      TOGGLE:  w_tog = bus.t;
      UP:      w_tog = w_up;
      DOWN:    w_tog = w_dn;
      LOAD:    w_tog = w_q ^ bus.d;
      default: w_tog = '0;
    endcase
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    tff_cell u_cell (
      .clk (clk),
      .clr (clr),
      .en  (bus.en),
      .tog (w_tog[i]),
      .q   (w_q[i]),
      .qn  (w_qn[i])
    );
  end

  assign w_tc = ((bus.mode == UP) && (w_q == c_max)) ||
                ((bus.mode == DOWN) && (w_q == '0));

  // A wrap is exactly tc taken at an enabled edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= bus.en & w_tc;
    end
  end

  assign bus.q     = w_q;
  assign bus.qn    = w_qn;
  assign bus.tc    = w_tc;
  assign bus.carry = r_carry;

endmodule

`default_nettype wire
